// File: rtl/sc_spi_pkg.sv
// Shared types and constants for the SPI target endpoint.
package sc_spi_pkg;
  localparam int MAXW = 32;
  localparam int CNTW = 5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } spi_state_e;

  // SPI mode number = {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef struct packed {
    logic            cpol;
    logic            cpha;
    logic            border;
    logic [CNTW-1:0] dwidth;
  } spi_cfg_t;

  function automatic logic [MAXW-1:0] bit_rev(input logic [MAXW-1:0] v);
    logic [MAXW-1:0] r;
    for (int i = 0; i < MAXW; i++) r[i] = v[MAXW-1-i];
    return r;
  endfunction
endpackage

// File: rtl/sc_spi_slave_if.sv
// Config, TX/RX handshake and SPI pin bundle of the SPI target.
interface sc_spi_slave_if;
  import sc_spi_pkg::*;

  logic            cpol;
  logic            cpha;
  logic            border;
  logic [CNTW-1:0] dwidth;
  logic [MAXW-1:0] txdata;
  logic            txvalid;
  logic            txready;
  logic [MAXW-1:0] rxdata;
  logic            rxvalid;
  logic            txunderrun;
  logic            rxabort;
  logic            selected;
  logic            csb;
  logic            sclk;
  logic            mosi;
  logic            miso;
  logic            misooe;

  modport slave (
    input  cpol, cpha, border, dwidth, txdata, txvalid, csb, sclk, mosi,
    output txready, rxdata, rxvalid, txunderrun, rxabort, selected, miso, misooe
  );

  modport master (
    output cpol, cpha, border, dwidth, txdata, txvalid, csb, sclk, mosi,
    input  txready, rxdata, rxvalid, txunderrun, rxabort, selected, miso, misooe
  );
endinterface

// File: rtl/sc_spi_slave_sync.sv
// Multi-flop synchronizers for CSB/SCLK/MOSI plus edge strobes on CSB and SCLK.
module sc_spi_slave_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic sysclk,
  input  logic sysrstb,
  input  logic csb_a,
  input  logic sclk_a,
  input  logic mosi_a,
  output logic csb_s,
  output logic mosi_s,
  output logic csb_fall,
  output logic csb_rise,
  output logic sclk_rise,
  output logic sclk_fall
);
  // bit order {mosi, sclk, csb}; CSB idles high so it resets to 1
  localparam logic [2:0] RST_VAL = 3'b001;

  logic [SYNC_STAGES-1:0][2:0] sync_q;
  logic [1:0]                  del_q;
  logic [2:0]                  s;
  logic [1:0]                  edg;

  // synchronizer chain plus one delay flop for CSB/SCLK edge detection
  always_ff @(posedge sysclk or negedge sysrstb) begin
    if (!sysrstb) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      del_q  <= RST_VAL[1:0];
    end else begin
      sync_q[0] <= {mosi_a, sclk_a, csb_a};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      del_q <= sync_q[SYNC_STAGES-1][1:0];
    end
  end

  assign s         = sync_q[SYNC_STAGES-1];
  assign edg       = s[1:0] ^ del_q;
  assign csb_s     = s[0];
  assign mosi_s    = s[2];
  assign csb_fall  = edg[0] & ~s[0];
  assign csb_rise  = edg[0] &  s[0];
  assign sclk_rise = edg[1] &  s[1];
  assign sclk_fall = edg[1] & ~s[1];
endmodule

// File: rtl/sc_spi_slave.sv
// SPI target endpoint: oversampled bus, one-entry TX buffer, per-word RX pulse.
module sc_spi_slave
  import sc_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic            sysclk,
  input logic            sysrstb,
  sc_spi_slave_if.slave  bus
);
  logic csb_s, mosi_s, csb_fall, csb_rise, sclk_rise, sclk_fall;

  sc_spi_slave_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .sysclk   (sysclk),
    .sysrstb  (sysrstb),
    .csb_a    (bus.csb),
    .sclk_a   (bus.sclk),
    .mosi_a   (bus.mosi),
    .csb_s    (csb_s),
    .mosi_s   (mosi_s),
    .csb_fall (csb_fall),
    .csb_rise (csb_rise),
    .sclk_rise(sclk_rise),
    .sclk_fall(sclk_fall)
  );

  spi_state_e      state_q, state_d;
  spi_cfg_t        cfg_q, cfg_cur;
  logic [CNTW-1:0] cnt_q;
  logic [MAXW-2:0] rx_sh_q;
  logic [MAXW-1:0] tx_sh_q, buf_q, rxdata_q;
  logic            buf_full_q, rxvalid_q, underrun_q, abort_q, miso_q, und_pend_q;

  logic            lead, trail, sample, drive, load, word_done, empty_load;
  logic [MAXW-1:0] load_word, aligned, ld_rest, dr_rest, rx_next, rx_word;
  logic            ld_head, dr_head;

  // in IDLE the live config inputs apply (they are latched at CSB fall)
  always_comb begin
    cfg_cur = cfg_q;
    if (state_q == ST_IDLE) begin
      cfg_cur.cpol   = bus.cpol;
      cfg_cur.cpha   = bus.cpha;
      cfg_cur.border = bus.border;
      cfg_cur.dwidth = bus.dwidth;
    end
  end

  // state register
  always_ff @(posedge sysclk or negedge sysrstb) begin
    if (!sysrstb) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // next state and per-cycle strobes; CSB rise overrides everything
  always_comb begin
    state_d   = state_q;
    lead      = cfg_q.cpol ? sclk_fall : sclk_rise;
    trail     = cfg_q.cpol ? sclk_rise : sclk_fall;
    sample    = 1'b0;
    drive     = 1'b0;
    load      = 1'b0;
    word_done = 1'b0;
    if (csb_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (csb_fall) begin
            state_d = ST_ACTIVE;
            load    = 1'b1;
          end
        end
        ST_ACTIVE: begin
          sample    = cfg_q.cpha ? trail : lead;
          // CPHA=0 already put bit 0 out at load, so the drive edge that
          // follows a word boundary must not advance the shifter
          drive     = (cfg_q.cpha ? lead : trail) && (cfg_q.cpha || cnt_q != '0);
          word_done = sample && (cnt_q == cfg_q.dwidth);
          load      = word_done;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // TX word selection: buffered word, same-cycle bypass, or zeros on underrun
  assign empty_load = !buf_full_q && !bus.txvalid;
  assign load_word  = buf_full_q ? buf_q : (bus.txvalid ? bus.txdata : '0);
  assign aligned    = cfg_cur.border ? load_word : (load_word << (5'd31 - cfg_cur.dwidth));
  assign ld_head    = cfg_cur.border ? aligned[0] : aligned[MAXW-1];
  assign ld_rest    = cfg_cur.border ? (aligned >> 1) : (aligned << 1);
  assign dr_head    = cfg_q.border ? tx_sh_q[0] : tx_sh_q[MAXW-1];
  assign dr_rest    = cfg_q.border ? (tx_sh_q >> 1) : (tx_sh_q << 1);
  assign rx_next    = {rx_sh_q, mosi_s};
  assign rx_word    = cfg_q.border ? (bit_rev(rx_next) >> (5'd31 - cfg_q.dwidth)) : rx_next;

  // shifters, counter, TX buffer and status pulses
  always_ff @(posedge sysclk or negedge sysrstb) begin
    if (!sysrstb) begin
      cfg_q      <= '0;
      cnt_q      <= '0;
      rx_sh_q    <= '0;
      tx_sh_q    <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      rxdata_q   <= '0;
      rxvalid_q  <= 1'b0;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
      miso_q     <= 1'b0;
      und_pend_q <= 1'b0;
    end else begin
      rxvalid_q  <= word_done;
      // underrun is reported when the starved word actually begins to
      // clock, so the idle reload after the final word stays silent
      underrun_q <= sample && und_pend_q;
      abort_q    <= csb_rise && (state_q == ST_ACTIVE) && (cnt_q != '0);
      if (word_done) rxdata_q <= rx_word;
      if (state_q == ST_IDLE && csb_fall) cfg_q <= cfg_cur;

      if (csb_rise) begin
        cnt_q      <= '0;
        miso_q     <= 1'b0;
        und_pend_q <= 1'b0;
      end else if (load) begin
        cnt_q      <= '0;
        rx_sh_q    <= '0;
        und_pend_q <= empty_load;
        if (!cfg_cur.cpha) begin
          miso_q  <= ld_head;
          tx_sh_q <= ld_rest;
        end else begin
          tx_sh_q <= aligned;
        end
      end else begin
        if (sample) begin
          rx_sh_q    <= rx_next[MAXW-2:0];
          cnt_q      <= cnt_q + 5'd1;
          und_pend_q <= 1'b0;
        end
        if (drive) begin
          miso_q  <= dr_head;
          tx_sh_q <= dr_rest;
        end
      end

      if (load) begin
        buf_full_q <= 1'b0;
      end else if (bus.txvalid && !buf_full_q) begin
        buf_full_q <= 1'b1;
        buf_q      <= bus.txdata;
      end
    end
  end

  assign bus.txready    = !buf_full_q;
  assign bus.rxdata     = rxdata_q;
  assign bus.rxvalid    = rxvalid_q;
  assign bus.txunderrun = underrun_q;
  assign bus.rxabort    = abort_q;
  assign bus.selected   = ~csb_s;
  assign bus.misooe     = ~csb_s;
  assign bus.miso       = miso_q;
endmodule

// File: tb/tb_sc_spi_slave.sv
// Bench for sc_spi_slave: behavioural SPI master plus RX scoreboard.
module tb_sc_spi_slave;
  import sc_spi_pkg::*;

  localparam int SS = 2;
  localparam int H  = 6;

  logic sysclk  = 1'b0;
  logic sysrstb = 1'b0;
  always #5 sysclk = ~sysclk;

  sc_spi_slave_if bus();

  sc_spi_slave #(.SYNC_STAGES(SS)) dut (
    .sysclk (sysclk),
    .sysrstb(sysrstb),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  int n_rxv = 0;
  int n_und = 0;
  int n_abt = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard: every RXVALID pops one expected word
  always @(negedge sysclk) begin
    if (bus.rxvalid) begin
      n_rxv++;
      chk("rx_pending", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) chk("rxdata", bus.rxdata, exp_q.pop_front());
    end
    if (bus.txunderrun) n_und++;
    if (bus.rxabort)    n_abt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic push_tx(input logic [31:0] d);
    int t = 0;
    while (!bus.txready && t < 2000) begin
      cyc(1);
      t++;
    end
    chk("txready_wait", 32'(t < 2000), 32'd1);
    bus.txdata  = d;
    bus.txvalid = 1'b1;
    cyc(1);
    bus.txvalid = 1'b0;
  endtask

  task automatic set_cfg(input logic cpol, input logic cpha, input logic border, input logic [4:0] dw);
    bus.cpol   = cpol;
    bus.cpha   = cpha;
    bus.border = border;
    bus.dwidth = dw;
    bus.sclk   = cpol;
    cyc(2 * H);
  endtask

  task automatic sel_on();
    bus.csb = 1'b0;
    cyc(H + 2);
  endtask

  task automatic sel_off();
    bus.csb = 1'b1;
    cyc(H);
  endtask

  // master shifts nbits of tx, returns what it sampled on MISO
  task automatic xfer(input int nbits, input logic [31:0] tx, output logic [31:0] rx);
    logic cpol, cpha, border;
    int   idx;
    cpol   = bus.cpol;
    cpha   = bus.cpha;
    border = bus.border;
    rx     = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = border ? i : int'(bus.dwidth) - i;
      if (!cpha) begin
        bus.mosi = tx[idx];
        cyc(H);
        rx[idx]  = bus.miso;
        bus.sclk = ~cpol;
        cyc(H);
        bus.sclk = cpol;
      end else begin
        bus.sclk = ~cpol;
        bus.mosi = tx[idx];
        cyc(H);
        rx[idx]  = bus.miso;
        bus.sclk = cpol;
        cyc(H);
      end
    end
    cyc(H);
  endtask

  initial begin
    logic [31:0] r, d;
    logic [1:0]  md;
    int v0, u0, a0;

    bus.csb = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.border = 1'b0; bus.dwidth = 5'd7;
    bus.txdata = '0; bus.txvalid = 1'b0;
    cyc(3);
    sysrstb = 1'b1;
    cyc(2);

    // reset state
    chk("rst_txready", 32'(bus.txready), 32'd1);
    chk("rst_rxdata", bus.rxdata, 32'd0);
    chk("rst_rxvalid", 32'(bus.rxvalid), 32'd0);
    chk("rst_selected", 32'(bus.selected), 32'd0);
    chk("rst_miso", 32'(bus.miso), 32'd0);
    chk("rst_misooe", 32'(bus.misooe), 32'd0);
    chk("rst_flags", 32'({bus.txunderrun, bus.rxabort}), 32'd0);

    // mode 0, 8-bit MSB first
    set_cfg(1'b0, 1'b0, 1'b0, 5'd7);
    v0 = n_rxv; u0 = n_und;
    push_tx(32'hA5);
    sel_on();
    chk("m0_selected", 32'(bus.selected), 32'd1);
    chk("m0_misooe", 32'(bus.misooe), 32'd1);
    chk("m0_txready", 32'(bus.txready), 32'd1);
    exp_q.push_back(32'h3C);
    xfer(8, 32'h3C, r);
    chk("m0_miso", r, 32'hA5);
    sel_off();
    chk("m0_rxv", 32'(n_rxv - v0), 32'd1);
    chk("m0_und", 32'(n_und - u0), 32'd0);
    chk("m0_sel_off", 32'(bus.selected), 32'd0);

    // modes 1..3, 32-bit LSB first
    for (int m = 1; m < 4; m++) begin
      md = (m == 1) ? SPI_MODE1 : (m == 2) ? SPI_MODE2 : SPI_MODE3;
      set_cfg(md[1], md[0], 1'b1, 5'd31);
      v0 = n_rxv; u0 = n_und;
      d = 32'hC0DE_0F00 ^ 32'(m * 32'h1111_0101);
      push_tx(d);
      sel_on();
      exp_q.push_back(32'h1234_5678);
      xfer(32, 32'h1234_5678, r);
      chk("m123_miso", r, d);
      sel_off();
      chk("m123_rxv", 32'(n_rxv - v0), 32'd1);
      chk("m123_und", 32'(n_und - u0), 32'd0);
    end

    // two words under one CSB, buffer refilled after first load
    set_cfg(1'b0, 1'b0, 1'b0, 5'd7);
    v0 = n_rxv; u0 = n_und;
    push_tx(32'h11);
    sel_on();
    push_tx(32'h22);
    exp_q.push_back(32'h5A);
    exp_q.push_back(32'hC3);
    xfer(8, 32'h5A, r);
    chk("b2b_miso0", r, 32'h11);
    xfer(8, 32'hC3, r);
    chk("b2b_miso1", r, 32'h22);
    sel_off();
    chk("b2b_rxv", 32'(n_rxv - v0), 32'd2);
    chk("b2b_und", 32'(n_und - u0), 32'd0);

    // two words, no refill: second word underruns and sends zeros
    v0 = n_rxv; u0 = n_und;
    push_tx(32'h33);
    sel_on();
    exp_q.push_back(32'h96);
    exp_q.push_back(32'h69);
    xfer(8, 32'h96, r);
    chk("ur_miso0", r, 32'h33);
    xfer(8, 32'h69, r);
    chk("ur_miso1", r, 32'h00);
    sel_off();
    chk("ur_rxv", 32'(n_rxv - v0), 32'd2);
    chk("ur_und", 32'(n_und - u0), 32'd1);

    // CSB rises after 3 of 8 bits
    v0 = n_rxv; a0 = n_abt;
    push_tx(32'h44);
    sel_on();
    xfer(3, 32'hF0, r);
    sel_off();
    chk("ab_abort", 32'(n_abt - a0), 32'd1);
    chk("ab_rxv", 32'(n_rxv - v0), 32'd0);
    chk("ab_rxdata", bus.rxdata, 32'h69);

    // TXVALID only on the load cycle with an empty buffer
    u0 = n_und;
    bus.csb = 1'b0;
    cyc(SS);
    bus.txdata  = 32'h5C;
    bus.txvalid = 1'b1;
    cyc(1);
    bus.txvalid = 1'b0;
    chk("byp_txready", 32'(bus.txready), 32'd1);
    cyc(H);
    exp_q.push_back(32'hE7);
    xfer(8, 32'hE7, r);
    chk("byp_miso", r, 32'h5C);
    sel_off();
    chk("byp_und", 32'(n_und - u0), 32'd0);

    // asynchronous reset in the middle of a word
    push_tx(32'h77);
    sel_on();
    xfer(4, 32'hAB, r);
    #2 sysrstb = 1'b0;
    #1;
    chk("ar_txready", 32'(bus.txready), 32'd1);
    chk("ar_rxdata", bus.rxdata, 32'd0);
    chk("ar_selected", 32'(bus.selected), 32'd0);
    chk("ar_miso", 32'(bus.miso), 32'd0);
    chk("ar_misooe", 32'(bus.misooe), 32'd0);
    chk("ar_flags", 32'({bus.rxvalid, bus.txunderrun, bus.rxabort}), 32'd0);
    bus.csb  = 1'b1;
    bus.sclk = 1'b0;
    cyc(3);
    sysrstb = 1'b1;
    cyc(4);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
